// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared defaults and producer latency constants for the scoreboard hazard unit.
package scoreboard_hazard_unit_pkg;

    localparam int unsigned NUM_REGS_DEF   = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned MAX_LAT_DEF    = 4;
    localparam int unsigned LAT_W_DEF      = 3;

    // Typical producer latencies, issue to forwardable result
    localparam int unsigned LAT_ALU = 1;
    localparam int unsigned LAT_LD  = 2;
    localparam int unsigned LAT_MUL = 4;

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage / write-back request bundle and the hazard unit's responses.
interface scoreboard_hazard_unit_if
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned LAT_W      = LAT_W_DEF
);

    logic                  forward_en;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src1_used;
    logic                  id_src2_used;
    logic                  id_wb_en;
    logic [REG_ADDR_W-1:0] id_dest;
    logic [LAT_W-1:0]      id_lat;
    logic                  flush;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  hazard_detected;
    logic                  issue;
    logic [NUM_REGS-1:0]   busy_vec;
    logic                  lat_err;

    // Pipeline side
    modport master (
        output forward_en, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
        output id_wb_en, id_dest, id_lat, flush, wb_valid, wb_dest,
        input  hazard_detected, issue, busy_vec, lat_err
    );

    // Hazard unit side
    modport slave (
        input  forward_en, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
        input  id_wb_en, id_dest, id_lat, flush, wb_valid, wb_dest,
        output hazard_detected, issue, busy_vec, lat_err
    );

endinterface

// File: rtl/scoreboard_hazard_unit_entry.sv
// Per-register scoreboard entry: pending flag plus cycles-until-forwardable counter.
module scoreboard_entry #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [LAT_W-1:0] load_cnt,
    output logic             pending,
    output logic [LAT_W-1:0] cnt
);

    // cnt is already relative to the cycle after the load, so a load of 0
    // means the value is on a forward path as soon as the producer issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            if (load) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end

            if (load) begin
                cnt <= load_cnt;
            end else if (cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Variable-latency scoreboard between ID and ID2EXE: RAW, WAW and write-back port stalls.
module scoreboard_hazard_unit
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned MAX_LAT    = LAT_MUL,
    parameter int unsigned LAT_W      = LAT_W_DEF,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    scoreboard_hazard_unit_if.slave bus
);

    logic [NUM_REGS-1:0] pending;
    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [MAX_LAT:1]    slot;
    logic [MAX_LAT:1]    slot_nxt;
    logic [LAT_W-1:0]    eff_lat;
    logic [LAT_W-1:0]    load_cnt;
    logic                lat_bad;
    logic                src1_chk;
    logic                src2_chk;
    logic                dest_wr;
    logic                raw1;
    logic                raw2;
    logic                waw;
    logic                structural;
    logic                hazard_c;
    logic                issue_c;
    logic                load;
    logic                lat_err;

    // Clamp the requested latency into 1..MAX_LAT and flag out-of-range requests
    always_comb begin
        lat_bad = 1'b0;
        eff_lat = bus.id_lat;
        if (bus.id_lat == '0) begin
            eff_lat = LAT_W'(1);
            lat_bad = 1'b1;
        end else if (32'(bus.id_lat) > MAX_LAT) begin
            eff_lat = LAT_W'(MAX_LAT);
            lat_bad = 1'b1;
        end
    end

    assign load_cnt = eff_lat - LAT_W'(1);

    assign src1_chk = bus.id_src1_used && !(ZERO_REG && (bus.id_src1 == '0));
    assign src2_chk = bus.id_src2_used && !(ZERO_REG && (bus.id_src2 == '0));
    assign dest_wr  = bus.id_wb_en && !(ZERO_REG && (bus.id_dest == '0));

    assign raw1 = src1_chk && pending[bus.id_src1]
               && (!bus.forward_en || (cnt[bus.id_src1] != '0));
    assign raw2 = src2_chk && pending[bus.id_src2]
               && (!bus.forward_en || (cnt[bus.id_src2] != '0));

    // An older write still completing after this one would be overtaken
    assign waw        = dest_wr && pending[bus.id_dest] && (cnt[bus.id_dest] > eff_lat);
    // slot[k] set means some write-back already lands k cycles from now
    assign structural = dest_wr && slot[eff_lat];

    assign hazard_c = bus.id_valid && !bus.flush && (raw1 || raw2 || waw || structural);
    assign issue_c  = bus.id_valid && !bus.flush && !hazard_c;
    assign load     = issue_c && dest_wr;

    // Shift reservations toward write-back; a new reservation merges in one step ahead
    always_comb begin
        slot_nxt = '0;
        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            slot_nxt[k] = slot[k+1] || (load && (eff_lat == LAT_W'(k + 1)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot    <= '0;
            lat_err <= 1'b0;
        end else begin
            slot    <= slot_nxt;
            lat_err <= lat_err || (issue_c && lat_bad);
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (load && (bus.id_dest == REG_ADDR_W'(r))),
            .clear    (bus.wb_valid && (bus.wb_dest == REG_ADDR_W'(r))),
            .load_cnt (load_cnt),
            .pending  (pending[r]),
            .cnt      (cnt[r])
        );
    end

    assign bus.hazard_detected = hazard_c;
    assign bus.issue           = issue_c;
    assign bus.busy_vec        = pending;
    assign bus.lat_err         = lat_err;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-time model.
module tb_scoreboard_hazard_unit;
    import scoreboard_hazard_unit_pkg::*;

    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned LW = 3;
    localparam int unsigned ML = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    scoreboard_hazard_unit_if #(.NUM_REGS(NR), .REG_ADDR_W(AW), .LAT_W(LW)) sb();

    scoreboard_hazard_unit #(
        .NUM_REGS   (NR),
        .REG_ADDR_W (AW),
        .MAX_LAT    (ML),
        .LAT_W      (LW),
        .ZERO_REG   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: absolute cycle at which each register becomes forwardable,
    // and the set of cycles in which a write-back is already booked.
    int cyc;
    bit m_pend [NR];
    int m_ready [NR];
    bit m_res [int];
    bit m_lat_err;

    function automatic int m_eff(int lat);
        if (lat == 0) return 1;
        if (lat > int'(ML)) return int'(ML);
        return lat;
    endfunction

    function automatic bit m_hazard();
        int L;
        bit raw, waw, st, dw;
        L   = m_eff(int'(sb.id_lat));
        dw  = sb.id_wb_en && (sb.id_dest != 0);
        raw = 0;
        if (sb.id_src1_used && sb.id_src1 != 0 && m_pend[sb.id_src1]
            && (!sb.forward_en || m_ready[sb.id_src1] > cyc)) raw = 1;
        if (sb.id_src2_used && sb.id_src2 != 0 && m_pend[sb.id_src2]
            && (!sb.forward_en || m_ready[sb.id_src2] > cyc)) raw = 1;
        waw = dw && m_pend[sb.id_dest] && (m_ready[sb.id_dest] > cyc + L);
        st  = dw && m_res.exists(cyc + L);
        return sb.id_valid && !sb.flush && (raw || waw || st);
    endfunction

    function automatic logic [NR-1:0] m_busy();
        logic [NR-1:0] v;
        for (int i = 0; i < int'(NR); i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_pend[i]  = 0;
            m_ready[i] = 0;
        end
        m_res.delete();
        m_lat_err = 0;
    endtask

    // Update the model from the inputs of this cycle, then advance one clock.
    task automatic tick();
        bit hz, iss;
        int L;
        hz  = m_hazard();
        iss = sb.id_valid && !sb.flush && !hz;
        L   = m_eff(int'(sb.id_lat));
        if (iss && (sb.id_lat == 0 || int'(sb.id_lat) > int'(ML))) m_lat_err = 1;
        if (sb.wb_valid) m_pend[sb.wb_dest] = 0;
        if (iss && sb.id_wb_en && sb.id_dest != 0) begin
            m_pend[sb.id_dest]  = 1;
            m_ready[sb.id_dest] = cyc + L;
            m_res[cyc + L]      = 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_id(bit v, int s1, bit u1, int s2, bit u2, bit we, int d, int lat);
        sb.id_valid     = v;
        sb.id_src1      = AW'(s1);
        sb.id_src1_used = u1;
        sb.id_src2      = AW'(s2);
        sb.id_src2_used = u2;
        sb.id_wb_en     = we;
        sb.id_dest      = AW'(d);
        sb.id_lat       = LW'(lat);
    endtask

    task automatic drive_idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 1);
        sb.flush      = 0;
        sb.wb_valid   = 0;
        sb.wb_dest    = '0;
        sb.forward_en = 1;
    endtask

    task automatic idle_cycles(int n);
        drive_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 0;
        @(posedge clk);
        #1;
        m_reset();
        rst = 1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0;
        set_id(1, 3, 1, 0, 0, 1, 3, LAT_ALU);
        m_reset();
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.hazard_detected !== 1'b0) begin
            errors++;
            $display("FAIL reset_hazard got %b exp 0", sb.hazard_detected);
        end
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL reset_issue got %b exp 1", sb.issue);
        end
        checks++;
        if (sb.busy_vec !== '0) begin
            errors++;
            $display("FAIL reset_busy got %h exp 0", sb.busy_vec);
        end
        checks++;
        if (sb.lat_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_lat_err got %b exp 0", sb.lat_err);
        end
        drive_idle();
        rst = 1;
    endtask

    task automatic test_fwd_raw();
        int  stalls;
        bit  done;
        idle_cycles(6);
        set_id(1, 0, 0, 0, 0, 1, 5, LAT_ALU);
        #1;
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL fwd_add_issue got %b exp 1", sb.issue);
        end
        tick();
        set_id(1, 5, 1, 0, 0, 1, 6, LAT_ALU);
        #1;
        checks++;
        if (sb.hazard_detected !== 1'b0) begin
            errors++;
            $display("FAIL fwd_alu_dep_hazard got %b exp 0", sb.hazard_detected);
        end
        tick();
        set_id(1, 0, 0, 0, 0, 1, 5, LAT_LD);
        #1;
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL fwd_ld_issue got %b exp 1", sb.issue);
        end
        tick();
        set_id(1, 5, 1, 0, 0, 1, 6, LAT_ALU);
        stalls = 0;
        done   = 0;
        for (int n = 0; n < 8 && !done; n++) begin
            #1;
            checks++;
            if (sb.hazard_detected !== m_hazard()) begin
                errors++;
                $display("FAIL fwd_ld_dep_hazard cyc %0d got %b exp %b", n, sb.hazard_detected, m_hazard());
            end
            if (sb.issue) done = 1;
            else stalls++;
            tick();
        end
        checks++;
        if (!done || stalls != 1) begin
            errors++;
            $display("FAIL fwd_ld_stall_count got %0d (issued %0b) exp 1", stalls, done);
        end
        drive_idle();
    endtask

    task automatic test_nofwd_raw();
        int  stalls;
        bit  done;
        idle_cycles(6);
        sb.forward_en = 0;
        set_id(1, 0, 0, 0, 0, 1, 5, LAT_ALU);
        #1;
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_add_issue got %b exp 1", sb.issue);
        end
        tick();
        set_id(1, 5, 1, 0, 0, 1, 10, LAT_ALU);
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            sb.wb_valid = (k == 3);
            sb.wb_dest  = AW'(5);
            #1;
            checks++;
            if (sb.hazard_detected !== m_hazard()) begin
                errors++;
                $display("FAIL nofwd_dep_hazard cyc %0d got %b exp %b", k, sb.hazard_detected, m_hazard());
            end
            if (sb.issue) begin
                done = 1;
                checks++;
                if (sb.busy_vec[5] !== 1'b0) begin
                    errors++;
                    $display("FAIL nofwd_busy5_after_wb got %b exp 0", sb.busy_vec[5]);
                end
            end else begin
                stalls++;
            end
            tick();
        end
        checks++;
        if (!done || stalls != 4) begin
            errors++;
            $display("FAIL nofwd_stall_count got %0d (issued %0b) exp 4", stalls, done);
        end
        drive_idle();
    endtask

    task automatic test_waw();
        int  stalls;
        bit  done;
        idle_cycles(6);
        set_id(1, 0, 0, 0, 0, 1, 7, LAT_MUL);
        #1;
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL waw_mul_issue got %b exp 1", sb.issue);
        end
        tick();
        set_id(1, 0, 0, 0, 0, 1, 7, LAT_ALU);
        stalls = 0;
        done   = 0;
        for (int n = 0; n < 8 && !done; n++) begin
            #1;
            checks++;
            if (sb.hazard_detected !== m_hazard()) begin
                errors++;
                $display("FAIL waw_hazard cyc %0d got %b exp %b", n, sb.hazard_detected, m_hazard());
            end
            checks++;
            if (sb.busy_vec[7] !== 1'b1) begin
                errors++;
                $display("FAIL waw_busy7 cyc %0d got %b exp 1", n, sb.busy_vec[7]);
            end
            if (sb.issue) done = 1;
            else stalls++;
            tick();
        end
        checks++;
        if (!done || stalls < 2) begin
            errors++;
            $display("FAIL waw_stall_count got %0d (issued %0b) exp at least 2", stalls, done);
        end
        drive_idle();
    endtask

    task automatic test_struct();
        int  stalls;
        bit  done;
        idle_cycles(6);
        set_id(1, 0, 0, 0, 0, 1, 8, LAT_MUL);
        #1;
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL struct_mul_issue got %b exp 1", sb.issue);
        end
        tick();
        idle_cycles(1);
        set_id(1, 0, 0, 0, 0, 1, 9, LAT_LD);
        stalls = 0;
        done   = 0;
        for (int n = 0; n < 8 && !done; n++) begin
            #1;
            checks++;
            if (sb.hazard_detected !== m_hazard()) begin
                errors++;
                $display("FAIL struct_hazard cyc %0d got %b exp %b", n, sb.hazard_detected, m_hazard());
            end
            if (sb.issue) done = 1;
            else stalls++;
            tick();
        end
        checks++;
        if (!done || stalls != 1) begin
            errors++;
            $display("FAIL struct_stall_count got %0d (issued %0b) exp 1", stalls, done);
        end
        drive_idle();
    endtask

    task automatic test_edges();
        int  stalls;
        bit  done;
        apply_reset();
        set_id(1, 0, 0, 0, 0, 1, 0, LAT_LD);
        #1;
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL r0_write_issue got %b exp 1", sb.issue);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (sb.busy_vec !== '0) begin
            errors++;
            $display("FAIL r0_write_busy got %h exp 0", sb.busy_vec);
        end
        // Out-of-range latency is clamped to the longest producer
        set_id(1, 0, 0, 0, 0, 1, 11, 7);
        #1;
        checks++;
        if (sb.issue !== 1'b1) begin
            errors++;
            $display("FAIL lat7_issue got %b exp 1", sb.issue);
        end
        tick();
        set_id(1, 11, 1, 0, 0, 0, 0, LAT_ALU);
        #1;
        checks++;
        if (sb.lat_err !== 1'b1) begin
            errors++;
            $display("FAIL lat7_lat_err got %b exp 1", sb.lat_err);
        end
        stalls = 0;
        done   = 0;
        for (int n = 0; n < 8 && !done; n++) begin
            if (n > 0) #1;
            if (sb.issue) done = 1;
            else stalls++;
            tick();
        end
        checks++;
        if (!done || stalls != 3) begin
            errors++;
            $display("FAIL lat7_stall_count got %0d (issued %0b) exp 3", stalls, done);
        end
        idle_cycles(4);
        set_id(1, 0, 0, 0, 0, 1, 12, LAT_LD);
        tick();
        set_id(1, 12, 1, 0, 0, 1, 13, LAT_ALU);
        sb.flush = 1;
        #1;
        checks++;
        if (sb.hazard_detected !== 1'b0) begin
            errors++;
            $display("FAIL flush_hazard got %b exp 0", sb.hazard_detected);
        end
        checks++;
        if (sb.issue !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue got %b exp 0", sb.issue);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (sb.busy_vec !== m_busy()) begin
            errors++;
            $display("FAIL flush_busy got %h exp %h", sb.busy_vec, m_busy());
        end
    endtask

    task automatic test_random();
        bit exp_hz;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset();
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 7),
                   ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4));
            sb.flush    = ($urandom_range(0, 7) == 0);
            sb.wb_valid = ($urandom_range(0, 2) == 0);
            sb.wb_dest  = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) sb.forward_en = ~sb.forward_en;
            #1;
            exp_hz = m_hazard();
            checks++;
            if (sb.hazard_detected !== exp_hz) begin
                errors++;
                $display("FAIL rand_hazard i %0d got %b exp %b", i, sb.hazard_detected, exp_hz);
            end
            checks++;
            if (sb.issue !== (sb.id_valid && !sb.flush && !exp_hz)) begin
                errors++;
                $display("FAIL rand_issue i %0d got %b exp %b", i, sb.issue, sb.id_valid && !sb.flush && !exp_hz);
            end
            checks++;
            if (sb.busy_vec !== m_busy()) begin
                errors++;
                $display("FAIL rand_busy i %0d got %h exp %h", i, sb.busy_vec, m_busy());
            end
            checks++;
            if (sb.lat_err !== m_lat_err) begin
                errors++;
                $display("FAIL rand_lat_err i %0d got %b exp %b", i, sb.lat_err, m_lat_err);
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 0;
        drive_idle();
        test_reset();
        test_fwd_raw();
        test_nofwd_raw();
        test_waw();
        test_struct();
        test_edges();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
